// File: rtl/serial_add_if.sv
// Request/result bundle for serial_add.
// The sub signal exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      output busy, done, sum, cout
   );
endinterface

// File: rtl/serial_add.sv
// Bit-serial adder: one full-adder cell, a carry flop and operand shift registers, LSB first.
// Define SERIAL_ADD_SUB_EN to add a subtract mode (a - b - borrow_in, cout = borrow out).
//
// state   | meaning
// IDLE    | waiting for start, operands captured on accept
// SHIFT   | one sum bit per cycle, WIDTH cycles
// DONE    | one-cycle done pulse, sum/cout just updated
module serial_add #(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   serial_add_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;
   localparam int         CW      = $clog2(WIDTH + 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc;
   logic             c;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   logic             s;
   logic             c_nxt;
   logic [WIDTH-1:0] acc_nxt;
   logic             last;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;
   logic             cout_fin;

`ifdef SERIAL_ADD_SUB_EN
   logic             sub_r;

   // Subtraction is a + ~b + ~bin; the final carry is the inverted borrow.
   always_comb begin
      b_ld     = bus.sub ? ~bus.b : bus.b;
      c_ld     = bus.sub ? ~bus.cin : bus.cin;
      cout_fin = sub_r ? ~c_nxt : c_nxt;
   end
`else
   always_comb begin
      b_ld     = bus.b;
      c_ld     = bus.cin;
      cout_fin = c_nxt;
   end
`endif

   always_comb begin
      s       = a_r[0] ^ b_r[0] ^ c;
      c_nxt   = (a_r[0] & b_r[0]) | (a_r[0] & c) | (b_r[0] & c);
      acc_nxt = {s, acc[WIDTH-1:1]};
      last    = (cnt == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         a_r    <= '0;
         b_r    <= '0;
         acc    <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
         sub_r  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  a_r   <= bus.a;
                  b_r   <= b_ld;
                  c     <= c_ld;
                  cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                  sub_r <= bus.sub;
`endif
                  state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               a_r <= a_r >> 1;
               b_r <= b_r >> 1;
               c   <= c_nxt;
               acc <= acc_nxt;
               cnt <= cnt + CW'(1);
               // Results are published straight from the last bit so the
               // partial accumulator never reaches the outputs.
               if (last) begin
                  sum_r  <= acc_nxt;
                  cout_r <= cout_fin;
                  state  <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = (state == S_SHIFT);
   assign bus.done = (state == S_DONE);
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add at WIDTH=8 plus an exhaustive WIDTH=2 instance.
// Subtract vectors are exercised when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add;
   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   serial_add_if #(.WIDTH(8)) bus8 ();
   serial_add_if #(.WIDTH(2)) bus2 ();

   serial_add #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   serial_add #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issues one request on the 8-bit instance and waits (bounded) for done.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub,
                      output int lat, output int busy_n, output logic [7:0] s, output logic co);
      @(negedge clk);
      bus8.start = 1'b1;
      bus8.a     = a;
      bus8.b     = b;
      bus8.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
      bus8.sub   = sub;
`endif
      if (sub) begin end
      @(negedge clk);
      bus8.start = 1'b0;
      lat    = -1;
      busy_n = 0;
      for (int i = 1; i <= 30; i++) begin
         if (bus8.busy) busy_n++;
         if (bus8.done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      s  = bus8.sum;
      co = bus8.cout;
   endtask

   task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic cin, input logic sub,
                      output int lat, output logic [2:0] res);
      @(negedge clk);
      bus2.start = 1'b1;
      bus2.a     = a;
      bus2.b     = b;
      bus2.cin   = cin;
`ifdef SERIAL_ADD_SUB_EN
      bus2.sub   = sub;
`endif
      if (sub) begin end
      @(negedge clk);
      bus2.start = 1'b0;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (bus2.done) begin
            lat = i;
            break;
         end
         @(negedge clk);
      end
      res = {bus2.cout, bus2.sum};
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         bn;
      int         pulses;
      int         prev;
      logic [7:0] s;
      logic       co;
      logic [2:0] r2;
      logic [2:0] e2;

      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      bus8.sub = 1'b0;
      bus2.sub = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", bus8.busy, 0);
      check("rst_done", bus8.done, 0);
      check("rst_sum",  bus8.sum,  0);
      check("rst_cout", bus8.cout, 0);
      rst = 1'b0;

      op8(8'h35, 8'h4A, 1'b0, 1'b0, lat, bn, s, co);
      check("basic_lat",  lat, 9);
      check("basic_busy", bn,  8);
      check("basic_sum",  s,   8'h7F);
      check("basic_cout", co,  0);
      @(negedge clk);
      check("basic_done_pulse", bus8.done, 0);
      check("basic_idle_busy",  bus8.busy, 0);

      op8(8'hFF, 8'h01, 1'b1, 1'b0, lat, bn, s, co);
      check("ff01_sum",  s,  8'h01);
      check("ff01_cout", co, 1);

      op8(8'hFF, 8'hFF, 1'b1, 1'b0, lat, bn, s, co);
      check("ones_sum",  s,  8'hFF);
      check("ones_cout", co, 1);

      // start raised during SHIFT must be ignored
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (2) @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
      @(negedge clk);
      bus8.start = 1'b0;
      pulses = 0;
      s = 8'h00; co = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus8.done) begin
            pulses++;
            s  = bus8.sum;
            co = bus8.cout;
         end
         @(negedge clk);
      end
      check("ign_pulses", pulses, 1);
      check("ign_sum",    s,      8'h30);
      check("ign_cout",   co,     0);
      check("ign_idle",   bus8.busy, 0);

      // reset in the 4th SHIFT cycle
      bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
      @(negedge clk);
      bus8.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_busy", bus8.busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", bus8.busy, 0);
      check("abort_done", bus8.done, 0);
      check("abort_sum",  bus8.sum,  0);
      check("abort_cout", bus8.cout, 0);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         if (bus8.done || bus8.busy) pulses++;
         @(negedge clk);
      end
      check("abort_quiet", pulses, 0);
      op8(8'hC0, 8'h80, 1'b1, 1'b0, lat, bn, s, co);
      check("post_rst_lat",  lat, 9);
      check("post_rst_sum",  s,   8'h41);
      check("post_rst_cout", co,  1);

      // start held high: one result every WIDTH+2 cycles
      @(negedge clk);
      bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01; bus8.cin = 1'b0;
      pulses = 0;
      prev   = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (bus8.done) begin
            pulses++;
            check("cont_sum", bus8.sum, 8'h02);
            check("cont_at", i, 9 + 10 * (pulses - 1));
            prev = i;
         end
      end
      bus8.start = 1'b0;
      check("cont_pulses", pulses, 4);
      check("cont_last",   prev,   39);
      repeat (12) @(negedge clk);

`ifdef SERIAL_ADD_SUB_EN
      op8(8'h10, 8'h20, 1'b0, 1'b1, lat, bn, s, co);
      check("sub1_lat",  lat, 9);
      check("sub1_sum",  s,   8'hF0);
      check("sub1_cout", co,  1);
      op8(8'h05, 8'h03, 1'b1, 1'b1, lat, bn, s, co);
      check("sub2_sum",  s,   8'h01);
      check("sub2_cout", co,  0);
      op8(8'h10, 8'h20, 1'b0, 1'b0, lat, bn, s, co);
      check("readd_sum",  s,  8'h30);
      check("readd_cout", co, 0);
`endif

      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int ci = 0; ci < 2; ci++) begin
               op2(2'(a), 2'(b), 1'(ci), 1'b0, lat, r2);
               e2 = 3'(a + b + ci);
               check("w2_add_lat", lat, 3);
               check("w2_add", r2, e2);
            end

`ifdef SERIAL_ADD_SUB_EN
      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int ci = 0; ci < 2; ci++) begin
               op2(2'(a), 2'(b), 1'(ci), 1'b1, lat, r2);
               e2 = {(a < b + ci) ? 1'b1 : 1'b0, 2'(a - b - ci)};
               check("w2_sub", r2, e2);
            end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
